// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone command initiator.
// Holds the FSM state encoding and the default bus geometry.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one bus cycle per command,
// read data or timeout error returned on the response port.
module wb_cmd_initiator
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT,
  parameter int TW      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic            busy_o
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  wb_state_e     state;
  logic [TW-1:0] cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            cnt         <= '0;
            state       <= BUS;
          end
        end
        BUS: begin
          // ack takes priority over the final timeout cycle
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (cnt == LAST) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator.
// Directed table, hand sequences and randomized transactions.
module tb_wb_cmd_initiator;

  localparam int TO = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_initiator #(
    .AW(32), .DW(32), .TIMEOUT(TO), .TW(8)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
    .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic [31:0] rd;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: responder acks after 'waits' wait states; abort
  // after TO bus cycles without ack.
  task automatic model(input logic we, input int waits,
                       input logic [31:0] rd, output logic err,
                       output logic [31:0] dat, output int ncyc);
    err  = (waits >= TO);
    dat  = (err || we) ? 32'h0 : rd;
    ncyc = err ? TO : waits + 1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !cmd_ready_o; i++) begin
      @(posedge wb_clk_i); #1;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready_o}, 32'h1);
  endtask

  task automatic do_txn(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int waits, input logic [31:0] rd,
                        input int hold, input logic exp_err,
                        input logic [31:0] exp_dat, input int exp_cyc);
    int  n;
    bit  stable;
    logic [31:0] r_dat;
    logic        r_err;
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b0;
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;
    chk("wbm_adr", wbm_adr_o, adr);
    chk("wbm_dat", wbm_dat_o, dat);
    chk("wbm_sel", {28'b0, wbm_sel_o}, {28'b0, sel});
    chk("wbm_we", {31'b0, wbm_we_o}, {31'b0, we});
    chk("busy_bus", {31'b0, busy_o}, 32'h1);
    n = 0;
    stable = 1'b1;
    while (wbm_cyc_o && n < 40) begin
      n++;
      if (!wbm_stb_o || wbm_adr_o !== adr || wbm_dat_o !== dat ||
          wbm_sel_o !== sel || wbm_we_o !== we || cmd_ready_o)
        stable = 1'b0;
      wbm_ack_i = (n == waits + 1);
      wbm_dat_i = wbm_ack_i ? rd : $urandom;
      @(posedge wb_clk_i); #1;
      wbm_ack_i = 1'b0;
    end
    chk("bus_stable", {31'b0, stable}, 32'h1);
    chk("cyc_cycles", n, exp_cyc);
    chk("stb_low", {31'b0, wbm_stb_o}, 32'h0);
    chk("sel_cleared", {28'b0, wbm_sel_o}, 32'h0);
    chk("dat_cleared", wbm_dat_o, 32'h0);
    chk("rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
    chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
    chk("rsp_dat", rsp_dat_o, exp_dat);
    r_dat = rsp_dat_o;
    r_err = rsp_err_o;
    for (int h = 0; h < hold; h++) begin
      wbm_ack_i = 1'($urandom);
      @(posedge wb_clk_i); #1;
      chk("hold_valid", {31'b0, rsp_valid_o}, 32'h1);
      chk("hold_dat", rsp_dat_o, r_dat);
      chk("hold_err", {31'b0, rsp_err_o}, {31'b0, r_err});
      chk("hold_ready", {31'b0, cmd_ready_o}, 32'h0);
      chk("hold_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    end
    wbm_ack_i   = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge wb_clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("rsp_drop", {31'b0, rsp_valid_o}, 32'h0);
    chk("rsp_dat_clr", rsp_dat_o, 32'h0);
    chk("ready_back", {31'b0, cmd_ready_o}, 32'h1);
    chk("busy_idle", {31'b0, busy_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e_err;
    logic [31:0] e_dat;
    int          e_cyc;
    logic        r_we;
    int          r_w;
    logic [31:0] r_rd;
    logic        cyc_h[40];
    logic [31:0] adr_h[40];
    int acc, rsp_n, rsp_e, rises, last_fall, gap_bad;
    logic [31:0] rise_adr[3];

    tbl[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0,
               32'h0, 0, 1'b0, 32'h0, 1};
    tbl[1] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, 3,
               32'h1234_5678, 0, 1'b0, 32'h1234_5678, 4};
    tbl[2] = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 100,
               32'hFFFF_FFFF, 0, 1'b1, 32'h0, 4};
    tbl[3] = '{1'b0, 32'h3000_0030, 32'h0, 4'hF, 0,
               32'hA5A5_A5A5, 10, 1'b0, 32'hA5A5_A5A5, 1};
    tbl[4] = '{1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'h3, 4,
               32'h0, 2, 1'b1, 32'h0, 4};
    tbl[5] = '{1'b0, 32'h0000_0044, 32'h0, 4'h3, 2,
               32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D, 3};

    wb_rst_n_i  = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
    chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    chk("rst_stb", {31'b0, wbm_stb_o}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i); #1;

    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
             tbl[i].waits, tbl[i].rd, tbl[i].hold,
             tbl[i].exp_err, tbl[i].exp_dat, tbl[i].exp_cyc);

    // back-to-back writes with valid and ready held high
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h0;
    cmd_dat_i   = 32'h1111_0000;
    cmd_sel_i   = 4'hF;
    rsp_ready_i = 1'b1;
    wbm_ack_i   = 1'b1;
    wbm_dat_i   = 32'hFFFF_FFFF;
    acc = 0; rsp_n = 0; rsp_e = 0;
    for (int c = 0; c < 24; c++) begin
      logic a, r;
      a = cmd_valid_i && cmd_ready_o;
      r = rsp_valid_o && rsp_ready_i;
      if (r && rsp_err_o) rsp_e++;
      @(posedge wb_clk_i); #1;
      if (r) rsp_n++;
      if (a) begin
        acc++;
        if (acc == 3) cmd_valid_i = 1'b0;
        else cmd_adr_i = 32'(acc * 4);
      end
      cyc_h[c] = wbm_cyc_o;
      adr_h[c] = wbm_adr_o;
    end
    wbm_ack_i   = 1'b0;
    rsp_ready_i = 1'b0;
    rises = 0; last_fall = -10; gap_bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0 && cyc_h[c-1] && !cyc_h[c]) last_fall = c;
      if (cyc_h[c] && (c == 0 || !cyc_h[c-1])) begin
        if (rises < 3) rise_adr[rises] = adr_h[c];
        if (rises > 0 && c - last_fall < 2) gap_bad++;
        rises++;
      end
    end
    chk("b2b_cycles", rises, 3);
    chk("b2b_adr0", rise_adr[0], 32'h0);
    chk("b2b_adr1", rise_adr[1], 32'h4);
    chk("b2b_adr2", rise_adr[2], 32'h8);
    chk("b2b_gaps", gap_bad, 0);
    chk("b2b_rsp", rsp_n, 3);
    chk("b2b_rsp_err", rsp_e, 0);

    // reset during the second wait cycle of a read
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h3000_0100;
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("pre_rst_cyc", {31'b0, wbm_cyc_o}, 32'h1);
    #2 wb_rst_n_i = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    chk("mid_rst_stb", {31'b0, wbm_stb_o}, 32'h0);
    chk("mid_rst_rsp", {31'b0, rsp_valid_o}, 32'h0);
    chk("mid_rst_ready", {31'b0, cmd_ready_o}, 32'h1);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("post_rst_ready", {31'b0, cmd_ready_o}, 32'h1);
    do_txn(1'b0, 32'h3000_0104, 32'h0, 4'hF, 1, 32'hCAFE_F00D,
           0, 1'b0, 32'hCAFE_F00D, 2);

    // randomized transactions against the reference
    for (int t = 0; t < 40; t++) begin
      r_we = 1'($urandom);
      r_w  = $urandom_range(0, 6);
      r_rd = $urandom;
      model(r_we, r_w, r_rd, e_err, e_dat, e_cyc);
      do_txn(r_we, $urandom, $urandom, 4'($urandom), r_w, r_rd,
             $urandom_range(0, 3), e_err, e_dat, e_cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic initiator (master) for the user area. It is the bus-driving end of the wbs_* responder interface the wrapper exposes.
- Takes single read/write commands on a valid/ready command port and runs one Wishbone classic cycle per command. Returns read data or an error on a valid/ready response port.
- Used to drive on-chip Wishbone responders (e.g. AES core register bank) from LA/IO-sourced command logic and in self-test.

Parameters:
- AW, 32, Wishbone address width.
- DW, 32, Wishbone data width (byte lanes = DW/8).
- TIMEOUT, 255, max cycles to wait for ack before aborting (must be ≥1).
- TW, 8, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- wb_clk_i  in  1  clock; all logic is rising-edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  AW  byte address.
- cmd_dat_i  in  DW  write data.
- cmd_sel_i  in  DW/8  byte enables.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  DW  read data (0 for writes and errors).
- rsp_err_o  out  1  1 = timeout abort.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DW/8  Wishbone byte select.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_ack_i  in  1  Wishbone ack.
- wbm_dat_i  in  DW  Wishbone read data.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0 except cmd_ready_o=1.
  - wbm_* = 0; rsp_* = 0; timeout counter = 0.
- FSM states: IDLE, BUS, RESP. All Wishbone outputs are registered.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch we/adr/dat/sel into wbm_* and set wbm_cyc_o=wbm_stb_o=1. Next state BUS, counter cleared.
- BUS:
  - cmd_ready_o=0. wbm_* held stable, cyc=stb=1.
  - wbm_ack_i sampled high: clear cyc/stb, we, sel, dat; capture rsp_dat_o = we ? 0 : wbm_dat_i; rsp_err_o=0; rsp_valid_o=1; go to RESP.
  - No ack and counter==TIMEOUT-1: clear cyc/stb; rsp_dat_o=0, rsp_err_o=1, rsp_valid_o=1; go to RESP. Otherwise increment the counter.
  - Abort occurs after exactly TIMEOUT bus cycles without ack.
- RESP:
  - cmd_ready_o=0; rsp_* held stable while rsp_ready_i=0.
  - On rsp_ready_i: rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0; go to IDLE.
- Latency with a zero-wait responder (ack in first BUS cycle):
  - accept at edge N; cyc/stb high after N.
  - rsp_valid_o high after N+1.
  - earliest next accept at N+3 if rsp_ready_i is held high.
- Only one outstanding transaction; no pipelined or burst mode.
- Ack outside BUS is ignored.
- wbm_adr_o holds its last value after the cycle ends; its value is don't-care when cyc=0. wbm_sel_o and wbm_dat_o are cleared to 0.
- Ack in the same cycle the counter reaches TIMEOUT-1: ack wins, no error.
- rsp_ready_i high while rsp_valid_o=0 has no effect.
- Reset mid-BUS drops cyc/stb asynchronously. The responder must tolerate the abandoned cycle.
- busy_o is registered and equals state != IDLE.

Decomposition:
- Shared package wb_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - default widths WB_AW=32, WB_DW=32;
  - WB_TIMEOUT_DEFAULT=255.
- No sub-module is needed. The timeout counter and FSM live in one module of about 150 lines.

Test Plan:
- Write, zero-wait: adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF.
  - cyc/stb/we high for 1 cycle with those values.
  - rsp_valid=1, rsp_err=0, rsp_dat=0.
- Read, 3 wait states: responder drives dat_i=0x1234_5678 with ack on the 4th BUS cycle.
  - cyc high for exactly 4 cycles.
  - rsp_dat=0x12345678, rsp_err=0.
- Timeout: TIMEOUT=4, no ack.
  - cyc high exactly 4 cycles, then drops.
  - rsp_valid=1, rsp_err=1, rsp_dat=0.
- Back-pressure: hold rsp_ready=0 for 10 cycles after a read of 0xA5A5_A5A5.
  - rsp stays stable, cmd_ready=0, no new cyc.
  - After rsp_ready=1, cmd_ready=1 on the next cycle.
- Back-to-back: 3 writes to 0x0, 0x4, 0x8 with cmd_valid and rsp_ready held high.
  - Three distinct cycles in order, each separated by ≥2 idle cycles.
  - Three rsp with err=0.
- Reset mid-BUS: assert wb_rst_n_i low during the 2nd wait cycle.
  - cyc/stb/rsp_valid go 0 immediately.
  - After release, cmd_ready=1 and a fresh read completes normally.
